// File: rtl/jy_mult_sched.sv
// Shares one iterative 8x8 multiplier between the JY $5800/$5801 port (A) and the
// MMC5 $5205/$5206 port (B): latches requests, arbitrates round-robin, returns products.
module jy_mult_sched #(
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] ABORT_VAL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req_a,
  input  logic [7:0]  a_op1,
  input  logic [7:0]  a_op2,
  output logic [15:0] res_a,
  output logic        done_a,
  output logic        busy_a,
  input  logic        req_b,
  input  logic [7:0]  b_op1,
  input  logic [7:0]  b_op2,
  output logic [15:0] res_b,
  output logic        done_b,
  output logic        busy_b,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  input  logic        mul_done,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t        state, state_next;
  logic          pend_a, pend_b;
  logic [7:0]    lat_a1, lat_a2, lat_b1, lat_b2;
  logic          owner_b;
  logic          last_grant_b;
  logic [TW-1:0] timer;
  logic          grant, grant_b, finish;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Ties go to the port that did not win last; GUARD swallows a done left over from the previous operation.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    grant      = 1'b0;
    grant_b    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_a || pend_b) begin
          grant      = 1'b1;
          grant_b    = pend_b && (!pend_a || !last_grant_b);
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        if (ce) state_next = S_GUARD;
      end
      S_GUARD: state_next = S_WAIT;
      S_WAIT: begin
        if (mul_done || timer == TW'(TIMEOUT)) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      lat_a1       <= '0;
      lat_a2       <= '0;
      lat_b1       <= '0;
      lat_b2       <= '0;
      owner_b      <= 1'b0;
      last_grant_b <= 1'b1;
      timer        <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      res_a        <= '0;
      res_b        <= '0;
      done_a       <= 1'b0;
      done_b       <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;

      // A fresh request outranks the grant-time clear, so a re-request is never lost.
      if (req_a) begin
        pend_a <= 1'b1;
        lat_a1 <= a_op1;
        lat_a2 <= a_op2;
      end else if (grant && !grant_b) begin
        pend_a <= 1'b0;
      end
      if (req_b) begin
        pend_b <= 1'b1;
        lat_b1 <= b_op1;
        lat_b2 <= b_op2;
      end else if (grant && grant_b) begin
        pend_b <= 1'b0;
      end

      if (grant) begin
        owner_b <= grant_b;
        mul_a   <= grant_b ? lat_b1 : lat_a1;
        mul_b   <= grant_b ? lat_b2 : lat_a2;
      end

      if (state == S_LAUNCH && ce) begin
        last_grant_b <= owner_b;
        timer        <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + 1'b1;
      end

      if (finish) begin
        if (owner_b) begin
          res_b  <= mul_done ? mul_p : ABORT_VAL;
          done_b <= 1'b1;
        end else begin
          res_a  <= mul_done ? mul_p : ABORT_VAL;
          done_a <= 1'b1;
        end
        if (!mul_done) timeout_err <= 1'b1;
      end
    end
  end

  assign busy_a = pend_a || (!owner_b && state != S_IDLE);
  assign busy_b = pend_b || ( owner_b && state != S_IDLE);

endmodule

// File: tb/tb_jy_mult_sched.sv
// Scoreboard bench for jy_mult_sched: a stimulus process queues expected products per port,
// a monitor pops and compares on every done pulse; a behavioural multiplier sits on the mul_* side.
module tb_jy_mult_sched;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        req_a, req_b;
  logic [7:0]  a_op1, a_op2, b_op1, b_op2;
  logic [15:0] res_a, res_b;
  logic        done_a, done_b, busy_a, busy_b;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic        mul_done;
  logic        timeout_err;

  jy_mult_sched dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .req_a(req_a), .a_op1(a_op1), .a_op2(a_op2), .res_a(res_a), .done_a(done_a), .busy_a(busy_a),
    .req_b(req_b), .b_op1(b_op1), .b_op2(b_op2), .res_b(res_b), .done_b(done_b), .busy_b(busy_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done),
    .timeout_err(timeout_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          done_log[$];
  logic [15:0] last_res_a = 16'h0;
  logic [15:0] last_res_b = 16'h0;
  int          start_cycles = 0;
  int          done_a_cnt = 0;
  int          starts = 0;
  bit          stale_seen = 0;
  logic        busy_a_at_done = 1'b1;
  bit          never_done = 0;
  int          ce_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-cycle multiplier; its done level drops one clk after a start is taken.
  logic        m_busy, m_clr;
  logic [2:0]  m_cnt;
  logic [15:0] m_prod;
  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy   <= 1'b0;
      m_clr    <= 1'b0;
      m_cnt    <= '0;
      m_prod   <= '0;
      mul_done <= 1'b0;
      mul_p    <= '0;
    end else begin
      if (m_clr) begin
        mul_done <= 1'b0;
        m_clr    <= 1'b0;
      end
      if (mul_start && ce && !m_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= '0;
        m_prod <= 16'(mul_a) * 16'(mul_b);
        m_clr  <= 1'b1;
        starts <= starts + 1;
      end else if (m_busy) begin
        if (m_cnt == 3'd7) begin
          m_busy <= 1'b0;
          if (!never_done) begin
            mul_done <= 1'b1;
            mul_p    <= m_prod;
          end
        end else begin
          m_cnt <= m_cnt + 3'd1;
        end
      end
    end
  end

  initial begin
    int phase;
    phase = 0;
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ce_mode)
        1: begin
          phase = (phase + 1) % 3;
          ce = (phase == 0);
        end
        2: ce = 1'($urandom_range(0, 1));
        default: ce = 1'b1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    logic [15:0] exp_v;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (mul_start === 1'b1) begin
          start_cycles++;
          if (mul_done === 1'b1) stale_seen = 1;
        end
        if (done_a === 1'b1) begin
          done_a_cnt++;
          done_log.push_back(0);
          busy_a_at_done = busy_a;
          if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_a_unexpected: got pulse with res_a=%0h, expected none", res_a);
          end else begin
            exp_v = qa.pop_front();
            checkOutput("res_a", 32'(res_a), 32'(exp_v));
            last_res_a = exp_v;
          end
          checkOutput("res_b_hold", 32'(res_b), 32'(last_res_b));
        end
        if (done_b === 1'b1) begin
          done_log.push_back(1);
          if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_b_unexpected: got pulse with res_b=%0h, expected none", res_b);
          end else begin
            exp_v = qb.pop_front();
            checkOutput("res_b", 32'(res_b), 32'(exp_v));
            last_res_b = exp_v;
          end
          checkOutput("res_a_hold", 32'(res_a), 32'(last_res_a));
        end
      end
    end
  end

  function automatic logic [15:0] expected_product(input logic [7:0] x, input logic [7:0] y);
    return never_done ? 16'hFFFF : 16'(x) * 16'(y);
  endfunction

  task automatic applyStimulus(input bit port_b, input logic [7:0] x, input logic [7:0] y, input bit push);
    if (port_b) begin
      req_b = 1'b1; b_op1 = x; b_op2 = y;
      if (push) qb.push_back(expected_product(x, y));
    end else begin
      req_a = 1'b1; a_op1 = x; a_op2 = y;
      if (push) qa.push_back(expected_product(x, y));
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic applyPair(input logic [7:0] xa, input logic [7:0] ya, input logic [7:0] xb, input logic [7:0] yb);
    req_a = 1'b1; a_op1 = xa; a_op2 = ya;
    req_b = 1'b1; b_op1 = xb; b_op2 = yb;
    qa.push_back(expected_product(xa, ya));
    qb.push_back(expected_product(xb, yb));
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d results outstanding after %0d clk, expected 0", qa.size(), qb.size(), budget);
    end
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_res_a"}, 32'(res_a), 32'h0);
    checkOutput({tag, "_res_b"}, 32'(res_b), 32'h0);
    checkOutput({tag, "_done"}, 32'({done_a, done_b}), 32'h0);
    checkOutput({tag, "_busy"}, 32'({busy_a, busy_b}), 32'h0);
    checkOutput({tag, "_mul_start"}, 32'(mul_start), 32'h0);
    checkOutput({tag, "_mul_ops"}, 32'({mul_a, mul_b}), 32'h0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    qa.delete();
    qb.delete();
    last_res_a = 16'h0;
    last_res_b = 16'h0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int s0, c0, d0;
    logic [7:0] x, y;
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    a_op1 = '0; a_op2 = '0; b_op1 = '0; b_op2 = '0;
    @(negedge clk);
    doReset();

    // Single A request with ce held high
    s0 = starts; c0 = start_cycles;
    applyStimulus(0, 8'h0C, 8'h0B, 1);
    waitDrain(100);
    checkOutput("t1_res_a", 32'(res_a), 32'h0084);
    checkOutput("t1_res_b", 32'(res_b), 32'h0);
    checkOutput("t1_start_cycles", 32'(start_cycles - c0), 32'd1);
    checkOutput("t1_mult_starts", 32'(starts - s0), 32'd1);
    checkOutput("t1_busy_at_done", 32'(busy_a_at_done), 32'h0);

    // Simultaneous pair straight after reset: A first, B's launch sees A's done still high
    doReset();
    stale_seen = 0;
    done_log.delete();
    applyPair(8'hFF, 8'hFF, 8'h10, 8'h10);
    waitDrain(200);
    checkOutput("pair1_res_a", 32'(res_a), 32'hFE01);
    checkOutput("pair1_res_b", 32'(res_b), 32'h0100);
    checkOutput("pair1_count", 32'(done_log.size()), 32'd2);
    checkOutput("pair1_first", 32'(done_log.size() > 0 ? done_log[0] : -1), 32'd0);
    checkOutput("pair1_stale_done_seen", 32'(stale_seen), 32'd1);

    // After a lone A operation, a tie must go to B
    applyStimulus(0, 8'h03, 8'h07, 1);
    waitDrain(100);
    done_log.delete();
    applyPair(8'h11, 8'h12, 8'h13, 8'h14);
    waitDrain(200);
    checkOutput("pair2_first", 32'(done_log.size() > 0 ? done_log[0] : -1), 32'd1);
    checkOutput("pair2_second", 32'(done_log.size() > 1 ? done_log[1] : -1), 32'd0);

    // ce every third clk: start held until taken, exactly one operation
    ce_mode = 1;
    s0 = starts; c0 = start_cycles;
    applyStimulus(1, 8'h2A, 8'h33, 1);
    waitDrain(300);
    checkOutput("ce_mult_starts", 32'(starts - s0), 32'd1);
    checkOutput("ce_start_held", 32'((start_cycles - c0) >= 1 && (start_cycles - c0) <= 3), 32'd1);
    ce_mode = 0;

    // Two A requests while B is in flight collapse into one A operation
    d0 = done_a_cnt;
    applyStimulus(1, 8'h05, 8'h06, 1);
    applyStimulus(0, 8'h02, 8'h03, 0);
    applyStimulus(0, 8'h04, 8'h05, 1);
    waitDrain(200);
    checkOutput("overwrite_res_a", 32'(res_a), 32'h0014);
    checkOutput("overwrite_done_count", 32'(done_a_cnt - d0), 32'd1);

    // Multiplier never finishes: abort value, sticky error
    never_done = 1;
    applyStimulus(0, 8'h07, 8'h09, 1);
    waitDrain(200);
    never_done = 0;
    checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
    applyStimulus(1, 8'h03, 8'h03, 1);
    waitDrain(100);
    checkOutput("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Randomised traffic with random ce
    ce_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0 && !busy_a && !busy_b) begin
        applyPair(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        x = 8'($urandom);
        y = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          if (!busy_b) applyStimulus(1, x, y, 1);
        end else begin
          if (!busy_a) applyStimulus(0, x, y, 1);
        end
      end
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    waitDrain(3000);
    ce_mode = 0;

    // Reset while the multiplier is running: everything clears, no done pulse
    d0 = done_a_cnt;
    applyStimulus(0, 8'h21, 8'h03, 0);
    repeat (6) @(negedge clk);
    doReset();
    repeat (20) @(negedge clk);
    checkOutput("midreset_no_done", 32'(done_a_cnt - d0), 32'd0);
    checkOutput("midreset_res_a_idle", 32'(res_a), 32'h0);

    applyStimulus(0, 8'h0C, 8'h0B, 1);
    waitDrain(100);
    checkOutput("post_reset_res_a", 32'(res_a), 32'h0084);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jy_mult_sched.md
Name: jy_mult_sched

Overview:
- Controller that shares one 8x8 iterative shift-add multiplier between two requesters.
- Port A: the JY Company $5800/$5801 multiplier registers. Port B: an MMC5-style $5205/$5206 multiplier.
- Latches each request, arbitrates round-robin, launches the multiplier on an M2 enable, waits for completion and returns the 16-bit product to the owning requester.
- Sits between the mapper register decode and the shared multiplier instance.

Parameters:
TIMEOUT, 15, clk cycles in WAIT before an operation is aborted.
ABORT_VAL, 16'hFFFF, product stored when an operation times out.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
ce  in  1  M2 enable; the multiplier only accepts start when ce=1
req_a  in  1  one-clk request pulse from port A
a_op1  in  8  port A multiplicand, sampled with req_a
a_op2  in  8  port A multiplier, sampled with req_a
res_a  out  16  last product for port A
done_a  out  1  one-clk pulse when res_a updates
busy_a  out  1  port A request pending or in flight
req_b, b_op1, b_op2, res_b, done_b, busy_b  same as port A, for port B
mul_start  out  1  start to the multiplier
mul_a  out  8  multiplicand to the multiplier
mul_b  out  8  multiplier to the multiplier
mul_p  in  16  product from the multiplier
mul_done  in  1  multiplier done level; may still be high from the previous operation
timeout_err  out  1  sticky flag, set on any abort

Behaviour:
Reset (reset_n=0 at a clk edge):
- state=IDLE; pend_a=pend_b=0; all operand latches 0.
- res_a=res_b=0; done_a=done_b=0; mul_start=0; mul_a=mul_b=0; timeout_err=0.
- last_grant=B, so port A wins the first tie.
- Reset mid-operation abandons the operation; no done pulse is emitted.

Request capture:
- req_x=1 sets pend_x and loads that port's operand latch.
- A new req_x while pend_x=1 overwrites the operands (latest wins); only one operation is performed.
- A new req_x while x is in flight sets pend_x again. The in-flight result is still delivered, then x is serviced again.
- busy_x = pend_x | (owner==x and state!=IDLE).

FSM:
- IDLE:
  - If exactly one port is pending, grant it.
  - If both are pending, grant the port that is not last_grant.
  - On grant: owner<=port, clear pend_owner, drive mul_a/mul_b from that port's latch, go to LAUNCH.
  - A request arriving in the same clk as the IDLE decision is not eligible until the next clk.
- LAUNCH:
  - mul_start=1, held until a clk with ce=1.
  - On that clk go to GUARD, set last_grant<=owner, clear timer.
- GUARD: one clk; mul_start=0; mul_done is ignored. This masks a stale done. Go to WAIT.
- WAIT:
  - timer increments each clk.
  - If mul_done=1: res_owner<=mul_p, pulse done_owner for one clk, go to IDLE.
  - Else if timer==TIMEOUT: res_owner<=ABORT_VAL, pulse done_owner, set timeout_err, go to IDLE.
  - mul_done has priority over timeout in the same clk.

Timing and registers:
- mul_a/mul_b are held stable from grant until the state returns to IDLE.
- Minimum latency from req to done is 12 clk with ce always 1 and an 8-cycle multiplier.
- Back-to-back requests are serviced with one IDLE clk between operations.
- res_x holds its value until the next completion for that port; the other port's completion never alters it.
- timeout_err is cleared only by reset.

Test Plan:
- Single A request: req_a with a_op1=8'h0C, a_op2=8'h0B, ce=1 constant -> mul_start for 1 clk; done_a pulses; res_a=16'h0084; res_b stays 0; busy_a drops on the same clk as done_a.
- Simultaneous A and B: req_a (FF,FF) and req_b (10,10) in the same clk after reset -> A serviced first, res_a=16'hFE01; then B, res_b=16'h0100. A second simultaneous pair -> B is serviced first.
- ce gating: ce pulses every 3rd clk -> mul_start stays high until the ce clk; exactly one operation starts; result is correct.
- Stale done: mul_done held high before launch -> no capture in GUARD; res captured only after mul_done goes low and returns high.
- Timeout: model never asserts mul_done -> after TIMEOUT clk in WAIT, res_a=16'hFFFF, done_a pulses, timeout_err=1 until reset.
- Overwrite and reset: two req_a before grant (02,03 then 04,05) -> single result 16'h0014. Then reset_n=0 during WAIT -> all outputs return to reset values, no done pulse.
